// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the mem_responder memory model.
// MEM_RESPONDER_RAND_LAT_EN (when defined) enables the LFSR-driven latency in mem_lat_timer.
package mem_resp_pkg;

    localparam int         WORD_W    = 32;
    localparam logic [7:0] LFSR_SEED = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    typedef enum logic {
        CH_IMEM,
        CH_DMEM
    } chan_e;

    // Fibonacci LFSR, taps 8,6,5,4 (bit 7 is tap 8), shifting towards the MSB.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/mem_lat_timer.sv
// Loadable access-latency down-counter with expiry flags.
// With MEM_RESPONDER_RAND_LAT_EN defined, each load picks 1 + (lfsr[3:0] mod LATENCY) cycles.
module mem_lat_timer
    import mem_resp_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic direct_o,
    output logic expire_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic [3:0] load_val;

`ifdef MEM_RESPONDER_RAND_LAT_EN
    logic [7:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else if (load_i) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign load_val = 4'({28'd0, lfsr_q[3:0]} % 32'(LATENCY));
`else
    assign load_val = 4'(LATENCY - 1);
`endif

    // A zero load value means a one-cycle access: the FSM skips BUSY entirely.
    assign direct_o = (load_val == 4'd0);
    assign expire_o = (cnt_q == 4'd1);

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val;
        end else if (dec_i && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder serving fetch and load/store request lines from one word array.
// Define MEM_RESPONDER_RAND_LAT_EN to randomise per-transaction latency in 1..LATENCY.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 1024,
    parameter int AW      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_req,
    input  logic [AW-1:0]     imem_addr,
    output logic [WORD_W-1:0] imem_rdata,
    output logic              imem_end,
    input  logic              dmem_req,
    input  logic              dmem_wen,
    input  logic [AW-1:0]     dmem_addr,
    input  logic [WORD_W-1:0] dmem_wdata,
    input  logic [3:0]        dmem_wmask,
    output logic [WORD_W-1:0] dmem_rdata,
    output logic              dmem_rend,
    output logic              dmem_wend
);

    localparam int IW = $clog2(DEPTH);

    logic [WORD_W-1:0] mem_q [DEPTH];

    state_e            state_q;
    chan_e             chan_q;
    logic              wen_q;
    logic [IW-1:0]     idx_q;
    logic [WORD_W-1:0] wdata_q;
    logic [3:0]        wmask_q;
    logic              imem_end_q;
    logic              dmem_rend_q;
    logic              dmem_wend_q;
    logic [WORD_W-1:0] imem_rdata_q;
    logic [WORD_W-1:0] dmem_rdata_q;

    logic              accept;
    logic              direct;
    logic              expire;
    logic              enter_resp;
    chan_e             nxt_chan;
    logic              nxt_wen;
    logic [IW-1:0]     nxt_idx;
    logic [WORD_W-1:0] rd_word;
    logic              unused_addr_bits;

    assign accept = (state_q == IDLE) && (dmem_req || imem_req);

    // Data channel has priority; a pending fetch stays requested and is taken next.
    always_comb begin
        nxt_chan = chan_q;
        nxt_wen  = wen_q;
        nxt_idx  = idx_q;
        if (accept) begin
            if (dmem_req) begin
                nxt_chan = CH_DMEM;
                nxt_wen  = dmem_wen;
                nxt_idx  = dmem_addr[IW+1:2];
            end else begin
                nxt_chan = CH_IMEM;
                nxt_wen  = 1'b0;
                nxt_idx  = imem_addr[IW+1:2];
            end
        end
    end

    assign enter_resp = (accept && direct) || (state_q == BUSY && expire);
    assign rd_word    = mem_q[nxt_idx];

    assign unused_addr_bits = ^{imem_addr[AW-1:IW+2], imem_addr[1:0],
                                dmem_addr[AW-1:IW+2], dmem_addr[1:0]};

    mem_lat_timer #(
        .LATENCY (LATENCY)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (accept),
        .dec_i    (state_q == BUSY),
        .direct_o (direct),
        .expire_o (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            imem_end_q   <= 1'b0;
            dmem_rend_q  <= 1'b0;
            dmem_wend_q  <= 1'b0;
            imem_rdata_q <= '0;
            dmem_rdata_q <= '0;
        end else begin
            imem_end_q  <= 1'b0;
            dmem_rend_q <= 1'b0;
            dmem_wend_q <= 1'b0;

            if (accept) begin
                chan_q  <= nxt_chan;
                wen_q   <= nxt_wen;
                idx_q   <= nxt_idx;
                wdata_q <= dmem_wdata;
                wmask_q <= dmem_wmask;
            end

            // End pulse and read data are registered on the edge that enters RESP.
            if (enter_resp) begin
                imem_end_q  <= (nxt_chan == CH_IMEM);
                dmem_rend_q <= (nxt_chan == CH_DMEM) && !nxt_wen;
                dmem_wend_q <= (nxt_chan == CH_DMEM) && nxt_wen;
                if (nxt_chan == CH_IMEM) begin
                    imem_rdata_q <= rd_word;
                end else if (!nxt_wen) begin
                    dmem_rdata_q <= rd_word;
                end
            end

            case (state_q)
                IDLE:    if (accept) state_q <= direct ? RESP : BUSY;
                BUSY:    if (expire) state_q <= RESP;
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; only the write port is gated by rst.
    always_ff @(posedge clk) begin
        if (!rst && state_q == RESP && chan_q == CH_DMEM && wen_q) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask_q[b]) begin
                    mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign imem_end   = imem_end_q;
    assign dmem_rend  = dmem_rend_q;
    assign dmem_wend  = dmem_wend_q;
    assign imem_rdata = imem_rdata_q;
    assign dmem_rdata = dmem_rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: vector table, priority, reset-abort and scoreboarded random traffic.
// Honours MEM_RESPONDER_RAND_LAT_EN by widening the latency check to 1..LATENCY.
module tb_mem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;
    localparam int AW    = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_end;
    logic        dmem_req;
    logic        dmem_wen;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_rdata;
    logic        dmem_rend;
    logic        dmem_wend;

    int n_tests = 0;
    int n_fail  = 0;

    mem_responder #(
        .LATENCY (LAT),
        .DEPTH   (DEPTH),
        .AW      (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_end   (imem_end),
        .dmem_req   (dmem_req),
        .dmem_wen   (dmem_wen),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_wmask (dmem_wmask),
        .dmem_rdata (dmem_rdata),
        .dmem_rend  (dmem_rend),
        .dmem_wend  (dmem_wend)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete transaction; request raised on a falling edge, outputs sampled on falling edges.
    task automatic run_txn(input string tag, input logic is_d, input logic wen,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wmask, input logic [31:0] exp);
        int          k;
        logic        seen;
        logic        own;
        logic        stray;
        logic [31:0] got;
        @(negedge clk);
        if (is_d) begin
            dmem_req = 1'b1; dmem_wen = wen; dmem_addr = addr;
            dmem_wdata = wdata; dmem_wmask = wmask;
        end else begin
            imem_req = 1'b1; imem_addr = addr;
        end
        k = 0; seen = 1'b0; stray = 1'b0; got = '0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            own = is_d ? (wen ? dmem_wend : dmem_rend) : imem_end;
            if ($countones({imem_end, dmem_rend, dmem_wend}) != (own ? 1 : 0)) stray = 1'b1;
            if (own) begin
                seen = 1'b1;
                got  = is_d ? dmem_rdata : imem_rdata;
            end else if (k == 1) begin
                // Inputs change mid-transaction; the latched values must be used.
                dmem_addr = ~dmem_addr; dmem_wdata = ~dmem_wdata;
                dmem_wmask = ~dmem_wmask; imem_addr = ~imem_addr;
            end
        end
        dmem_req = 1'b0; imem_req = 1'b0;
`ifdef MEM_RESPONDER_RAND_LAT_EN
        check({tag, "_lat_in_range"}, 32'(k >= 1 && k <= LAT), 32'd1);
`else
        check({tag, "_lat"}, 32'(k), 32'(LAT));
`endif
        check({tag, "_stray_end"}, {31'd0, stray}, 32'd0);
        if (!(is_d && wen)) check({tag, "_rdata"}, got, exp);
        @(negedge clk);
        check({tag, "_pulse_width"}, {29'd0, imem_end, dmem_rend, dmem_wend}, 32'd0);
    endtask

    logic [31:0] sb [16];

    initial begin
        int          dcyc;
        int          icyc;
        int          pulses;
        logic [31:0] dgot;
        logic [31:0] igot;
        int          n_rand;

        vecs[0]  = '{1'b1, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,        4'h0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h0000_0000, 4'hF, 32'h0};
        vecs[3]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h11223344, 4'b0101, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,        4'h0, 32'h00220044};
        vecs[5]  = '{1'b1, 1'b1, 32'h0000_1000, 32'hCAFEF00D, 4'hF, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,        4'h0, 32'hCAFEF00D};
        vecs[7]  = '{1'b1, 1'b1, 32'h0000_0020, 32'hFFFFFFFF, 4'h0, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_0023, 32'h0,        4'h0, 32'h00220044};
        vecs[9]  = '{1'b0, 1'b0, 32'h0000_1002, 32'h0,        4'h0, 32'hCAFEF00D};
        vecs[10] = '{1'b1, 1'b1, 32'h0000_0020, 32'hAABBCCDD, 4'b1010, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,        4'h0, 32'hAA22CC44};
        vecs[12] = '{1'b0, 1'b0, 32'hFFFF_F010, 32'h0,        4'h0, 32'hDEADBEEF};

        rst = 1'b1; imem_req = 1'b0; imem_addr = '0; dmem_req = 1'b0; dmem_wen = 1'b0;
        dmem_addr = '0; dmem_wdata = '0; dmem_wmask = '0;
        repeat (3) @(negedge clk);
        check("reset_ends", {29'd0, imem_end, dmem_rend, dmem_wend}, 32'd0);
        check("reset_imem_rdata", imem_rdata, 32'd0);
        check("reset_dmem_rdata", dmem_rdata, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].is_d, vecs[i].wen, vecs[i].addr,
                    vecs[i].wdata, vecs[i].wmask, vecs[i].exp);
        end
        check("rdata_hold", dmem_rdata, 32'hAA22CC44);

        // Both requests in the same cycle: data first, fetch served right after.
        @(negedge clk);
        dmem_req = 1'b1; dmem_wen = 1'b0; dmem_addr = 32'h10;
        imem_req = 1'b1; imem_addr = 32'h10;
        dcyc = 0; icyc = 0; dgot = '0; igot = '0;
        for (int k = 1; k <= 40 && icyc == 0; k++) begin
            @(negedge clk);
            if (dmem_rend) begin dcyc = k; dgot = dmem_rdata; dmem_req = 1'b0; end
            if (imem_end)  begin icyc = k; igot = imem_rdata; imem_req = 1'b0; end
        end
        dmem_req = 1'b0; imem_req = 1'b0;
`ifdef MEM_RESPONDER_RAND_LAT_EN
        check("both_d_lat", 32'(dcyc >= 1 && dcyc <= LAT), 32'd1);
        check("both_i_after_d", 32'(icyc - dcyc >= 2 && icyc - dcyc <= LAT + 1), 32'd1);
`else
        check("both_d_cycle", 32'(dcyc), 32'(LAT));
        check("both_i_cycle", 32'(icyc), 32'(2 * LAT + 1));
`endif
        check("both_d_data", dgot, 32'hDEADBEEF);
        check("both_i_data", igot, 32'hDEADBEEF);
        @(negedge clk);

        // Reset during a store: nothing commits, no end pulse, clean restart.
        run_txn("rst_pre", 1'b1, 1'b1, 32'h30, 32'h55AA55AA, 4'hF, 32'h0);
        @(negedge clk);
        dmem_req = 1'b1; dmem_wen = 1'b1; dmem_addr = 32'h30;
        dmem_wdata = 32'hFFFFFFFF; dmem_wmask = 4'hF;
        @(negedge clk);
        pulses = 0;
`ifndef MEM_RESPONDER_RAND_LAT_EN
        pulses += $countones({imem_end, dmem_rend, dmem_wend});
`endif
        rst = 1'b1; dmem_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_imem_rdata", imem_rdata, 32'd0);
        check("rst_mid_dmem_rdata", dmem_rdata, 32'd0);
        for (int k = 0; k < 6; k++) begin
            pulses += $countones({imem_end, dmem_rend, dmem_wend});
            @(negedge clk);
        end
        check("rst_mid_no_end", 32'(pulses), 32'd0);
        run_txn("rst_word_kept", 1'b1, 1'b0, 32'h30, 32'h0, 4'h0, 32'h55AA55AA);
        run_txn("rst_fetch_after", 1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF);

        // Scoreboarded random traffic over words 64..79.
        for (int i = 0; i < 16; i++) begin
            sb[i] = $urandom;
            run_txn($sformatf("init%0d", i), 1'b1, 1'b1, 32'h100 + 32'(4 * i), sb[i], 4'hF, 32'h0);
        end
`ifdef MEM_RESPONDER_RAND_LAT_EN
        n_rand = 200;
`else
        n_rand = 40;
`endif
        for (int t = 0; t < n_rand; t++) begin
            int          w;
            logic [1:0]  op;
            logic [31:0] wd;
            logic [3:0]  wm;
            w  = $urandom_range(0, 15);
            op = 2'($urandom_range(0, 2));
            wd = $urandom;
            wm = 4'($urandom_range(0, 15));
            if (op == 2'd0) begin
                run_txn($sformatf("rnd%0d_st", t), 1'b1, 1'b1, 32'h100 + 32'(4 * w), wd, wm, 32'h0);
                for (int b = 0; b < 4; b++) begin
                    if (wm[b]) sb[w][8*b +: 8] = wd[8*b +: 8];
                end
            end else if (op == 2'd1) begin
                run_txn($sformatf("rnd%0d_ld", t), 1'b1, 1'b0, 32'h100 + 32'(4 * w), 32'h0, 4'h0, sb[w]);
            end else begin
                run_txn($sformatf("rnd%0d_if", t), 1'b0, 1'b0, 32'h100 + 32'(4 * w), 32'h0, 4'h0, sb[w]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
